// File: rtl/parking_exit_if.sv
// parking_exit_if: entry, exit request and exit response bundle of the parking exit controller
interface parking_exit_if #(
  parameter int SLOTS  = 8,
  parameter int TIME_W = 8
);
  logic              enter_valid;
  logic [SLOTS-1:0]  enter_location;
  logic              enter_ack;
  logic              exit_valid;
  logic [SLOTS-1:0]  exit_location;
  logic              exit_ready;
  logic [SLOTS-1:0]  parking_capacity;
  logic              resp_valid;
  logic [1:0]        resp_error;
  logic [TIME_W-1:0] resp_duration;
  modport master (
    output enter_valid, enter_location, exit_valid, exit_location,
    input  enter_ack, exit_ready, parking_capacity, resp_valid, resp_error, resp_duration
  );
  modport slave (
    input  enter_valid, enter_location, exit_valid, exit_location,
    output enter_ack, exit_ready, parking_capacity, resp_valid, resp_error, resp_duration
  );
endinterface

// File: rtl/parking_exit_controller.sv
// parking_exit_controller: owns the slot occupancy bitmap, accepts entries, validates and releases exits with parked time
module parking_exit_controller #(
  parameter int SLOTS    = 8,
  parameter int TIME_W   = 8,
  parameter int TICK_DIV = 10
) (
  input logic          clk,
  input logic          rst,
  parking_exit_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CHECK   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;
  localparam int CNT_W = $clog2(TICK_DIV);
  logic [1:0]                   state;
  logic [SLOTS-1:0]             cap, loc_q, set_mask, clr_mask;
  logic [SLOTS-1:0][TIME_W-1:0] timer;
  logic [TIME_W-1:0]            dur_q, loc_time;
  logic [1:0]                   err_q;
  logic [CNT_W-1:0]             tick_cnt;
  logic                         tick, ack_q, enter_ok, enter_onehot, loc_onehot;
  assign tick         = tick_cnt == CNT_W'(TICK_DIV - 1);
  assign enter_onehot = |bus.enter_location && ((bus.enter_location & (bus.enter_location - SLOTS'(1))) == '0);
  assign loc_onehot   = |loc_q && ((loc_q & (loc_q - SLOTS'(1))) == '0);
  // an entry onto the slot being released still sees it occupied, so it is refused
  assign enter_ok     = bus.enter_valid && enter_onehot && !(|(bus.enter_location & cap));
  assign set_mask     = enter_ok ? bus.enter_location : '0;
  assign clr_mask     = state == RELEASE ? loc_q : '0;
  always_comb begin
    loc_time = '0;
    for (int i = 0; i < SLOTS; i++) loc_time = loc_time | (loc_q[i] ? timer[i] : '0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) timer <= '0;
    else
      for (int i = 0; i < SLOTS; i++)
        if (set_mask[i]) timer[i] <= '0;
        else if (tick && cap[i] && timer[i] != '1) timer[i] <= timer[i] + TIME_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      cap      <= '0;
      loc_q    <= '0;
      err_q    <= '0;
      dur_q    <= '0;
      tick_cnt <= '0;
      ack_q    <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
      ack_q    <= enter_ok;
      cap      <= (cap | set_mask) & ~clr_mask;
      case (state)
        IDLE: if (bus.exit_valid) begin
          loc_q <= bus.exit_location;
          state <= CHECK;
        end
        CHECK: if (!loc_onehot || !(|(loc_q & cap))) begin
          err_q <= loc_onehot ? 2'b10 : 2'b01;
          dur_q <= '0;
          state <= RESP;
        end else state <= RELEASE;
        RELEASE: begin
          err_q <= 2'b00;
          dur_q <= loc_time;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.enter_ack        = ack_q;
  assign bus.exit_ready       = state == IDLE;
  assign bus.parking_capacity = cap;
  assign bus.resp_valid       = state == RESP;
  assign bus.resp_error       = err_q;
  assign bus.resp_duration    = dur_q;
endmodule

// File: tb/tb_parking_exit_controller.sv
// tb_parking_exit_controller: directed and randomized checks against a schedule-based reference model
module tb_parking_exit_controller;
  localparam int SLOTS = 8, TIME_W = 8, TICK_DIV = 10, TMAX = 255;
  logic clk = 1'b0;
  logic rst = 1'b1;
  parking_exit_if #(.SLOTS(SLOTS), .TIME_W(TIME_W)) bus ();
  parking_exit_controller #(.SLOTS(SLOTS), .TIME_W(TIME_W), .TICK_DIV(TICK_DIV)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_checks = 0, n_fail = 0;
  logic [7:0] m_cap, m_loc;
  int m_tmr[SLOTS];
  int m_edge, m_rel_edge, m_resp_edge, m_ready_edge, m_dur;
  bit m_pend, m_ready, m_ack, m_rv;
  logic [1:0] m_err;
  task automatic model_reset();
    m_cap = '0; m_loc = '0; m_edge = 0; m_pend = 0; m_ready = 1; m_ack = 0; m_rv = 0;
    m_err = '0; m_dur = 0; m_rel_edge = -1; m_resp_edge = -1; m_ready_edge = -1;
    for (int i = 0; i < SLOTS; i++) m_tmr[i] = 0;
  endtask
  // advance the model by one clock edge using the inputs currently driven
  task automatic model_step();
    logic [7:0] old, set, clr;
    bit tk;
    old = m_cap; set = '0; clr = '0;
    tk = (m_edge % TICK_DIV) == TICK_DIV - 1;
    m_ack = bus.enter_valid && $countones(bus.enter_location) == 1 && (old & bus.enter_location) == 0;
    if (m_ack) set = bus.enter_location;
    if (m_pend && m_edge == m_rel_edge) begin
      clr = m_loc;
      for (int i = 0; i < SLOTS; i++) if (m_loc[i]) m_dur = m_tmr[i];
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (tk && old[i]) m_tmr[i] = m_tmr[i] < TMAX ? m_tmr[i] + 1 : TMAX;
      if (set[i]) m_tmr[i] = 0;
    end
    m_cap = (old | set) & ~clr;
    if (bus.exit_valid && m_ready) begin
      m_pend = 1;
      m_loc = bus.exit_location;
      if ($countones(m_loc) != 1) begin m_err = 2'b01; m_dur = 0; m_resp_edge = m_edge + 1; m_rel_edge = -1; end
      else if ((m_loc & m_cap) == 0) begin m_err = 2'b10; m_dur = 0; m_resp_edge = m_edge + 1; m_rel_edge = -1; end
      else begin m_err = 2'b00; m_rel_edge = m_edge + 2; m_resp_edge = m_edge + 2; end
      m_ready_edge = m_resp_edge + 1;
    end
    m_rv = m_pend && m_edge == m_resp_edge;
    if (m_pend && m_edge == m_ready_edge) m_pend = 0;
    m_ready = !m_pend;
    m_edge++;
  endtask
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.enter_valid = 0; bus.enter_location = '0; bus.exit_valid = 0; bus.exit_location = '0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask
  task automatic test_reset();
    idle_inputs();
    #1;
    n_checks++;
    if ({bus.exit_ready, bus.enter_ack, bus.resp_valid, bus.resp_error, bus.resp_duration, bus.parking_capacity} !== {1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b ack=%b rv=%b err=%b dur=%h cap=%h, required ready=1 ack=0 rv=0 err=00 dur=00 cap=00",
               bus.exit_ready, bus.enter_ack, bus.resp_valid, bus.resp_error, bus.resp_duration, bus.parking_capacity);
    end
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask
  task automatic test_entry();
    bus.enter_valid = 1; bus.enter_location = 8'h01;
    cycle();
    n_checks++;
    if (bus.enter_ack !== 1'b1 || bus.parking_capacity !== 8'h01) begin
      n_fail++; $display("FAIL enter_first: ack=%b cap=%h, required ack=1 cap=01", bus.enter_ack, bus.parking_capacity);
    end
    cycle();
    n_checks++;
    if (bus.enter_ack !== 1'b0 || bus.parking_capacity !== 8'h01) begin
      n_fail++; $display("FAIL enter_repeat: ack=%b cap=%h, required ack=0 cap=01", bus.enter_ack, bus.parking_capacity);
    end
    bus.enter_location = 8'h03;
    cycle();
    n_checks++;
    if (bus.enter_ack !== 1'b0 || bus.parking_capacity !== 8'h01) begin
      n_fail++; $display("FAIL enter_not_onehot: ack=%b cap=%h, required ack=0 cap=01", bus.enter_ack, bus.parking_capacity);
    end
    idle_inputs();
  endtask
  task automatic test_exit_ok();
    bus.enter_valid = 1; bus.enter_location = 8'h04;
    cycle();
    idle_inputs();
    repeat (30) cycle();
    bus.exit_valid = 1; bus.exit_location = 8'h04;
    cycle();
    bus.exit_valid = 0;
    n_checks++;
    if (bus.exit_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL exit_accept: ready=%b rv=%b, required ready=0 rv=0", bus.exit_ready, bus.resp_valid);
    end
    cycle();
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL exit_release_early: rv=%b, required 0", bus.resp_valid);
    end
    cycle();
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_error !== 2'b00 || bus.resp_duration !== 8'(m_dur) || bus.parking_capacity !== 8'h01) begin
      n_fail++;
      $display("FAIL exit_ok_resp: rv=%b err=%b dur=%0d cap=%h, required rv=1 err=00 dur=%0d cap=01",
               bus.resp_valid, bus.resp_error, bus.resp_duration, bus.parking_capacity, m_dur);
    end
    cycle();
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.exit_ready !== 1'b1 || bus.resp_duration !== 8'(m_dur)) begin
      n_fail++; $display("FAIL exit_ok_after: rv=%b ready=%b dur=%0d, required rv=0 ready=1 dur=%0d", bus.resp_valid, bus.exit_ready, bus.resp_duration, m_dur);
    end
  endtask
  task automatic test_exit_errors();
    logic [7:0] locs[2];
    logic [1:0] errs[2];
    locs[0] = 8'h03; errs[0] = 2'b01;
    locs[1] = 8'h80; errs[1] = 2'b10;
    for (int k = 0; k < 2; k++) begin
      bus.exit_valid = 1; bus.exit_location = locs[k];
      cycle();
      bus.exit_valid = 0;
      cycle();
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_error !== errs[k] || bus.resp_duration !== 8'h00 || bus.parking_capacity !== 8'h01) begin
        n_fail++;
        $display("FAIL exit_err_%h: rv=%b err=%b dur=%0d cap=%h, required rv=1 err=%b dur=0 cap=01",
                 locs[k], bus.resp_valid, bus.resp_error, bus.resp_duration, bus.parking_capacity, errs[k]);
      end
      cycle();
      n_checks++;
      if (bus.exit_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL exit_err_ready_%h: ready=%b rv=%b, required ready=1 rv=0", locs[k], bus.exit_ready, bus.resp_valid);
      end
    end
  endtask
  task automatic test_simultaneous();
    logic [7:0] ent[2];
    logic [7:0] want_cap[2];
    logic want_ack[2];
    ent[0] = 8'h02; want_ack[0] = 0; want_cap[0] = 8'h01;
    ent[1] = 8'h10; want_ack[1] = 1; want_cap[1] = 8'h11;
    for (int k = 0; k < 2; k++) begin
      bus.enter_valid = 1; bus.enter_location = 8'h02;
      cycle();
      bus.enter_valid = 0;
      bus.exit_valid = 1; bus.exit_location = 8'h02;
      cycle();
      bus.exit_valid = 0;
      cycle();
      bus.enter_valid = 1; bus.enter_location = ent[k];
      cycle();
      bus.enter_valid = 0;
      n_checks++;
      if (bus.enter_ack !== want_ack[k] || bus.resp_valid !== 1'b1 || bus.resp_error !== 2'b00 || bus.parking_capacity !== want_cap[k]) begin
        n_fail++;
        $display("FAIL release_with_entry_%h: ack=%b rv=%b err=%b cap=%h, required ack=%b rv=1 err=00 cap=%h",
                 ent[k], bus.enter_ack, bus.resp_valid, bus.resp_error, bus.parking_capacity, want_ack[k], want_cap[k]);
      end
      cycle();
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.enter_valid = $urandom_range(0, 1) == 1;
      bus.enter_location = $urandom_range(0, 4) == 0 ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      bus.exit_valid = $urandom_range(0, 2) == 0;
      bus.exit_location = $urandom_range(0, 4) == 0 ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      cycle();
      n_checks++;
      if (bus.parking_capacity !== m_cap || bus.enter_ack !== m_ack || bus.exit_ready !== m_ready || bus.resp_valid !== m_rv) begin
        n_fail++;
        $display("FAIL random_state@%0d: cap=%h ack=%b ready=%b rv=%b, required cap=%h ack=%b ready=%b rv=%b",
                 c, bus.parking_capacity, bus.enter_ack, bus.exit_ready, bus.resp_valid, m_cap, m_ack, m_ready, m_rv);
      end
      if (m_rv) begin
        n_checks++;
        if (bus.resp_error !== m_err || bus.resp_duration !== 8'(m_dur)) begin
          n_fail++;
          $display("FAIL random_resp@%0d: err=%b dur=%0d, required err=%b dur=%0d", c, bus.resp_error, bus.resp_duration, m_err, m_dur);
        end
      end
    end
    idle_inputs();
  endtask
  task automatic test_saturation();
    do_reset();
    bus.enter_valid = 1; bus.enter_location = 8'h01;
    cycle();
    idle_inputs();
    repeat (25700) cycle();
    bus.exit_valid = 1; bus.exit_location = 8'h01;
    cycle();
    bus.exit_valid = 0;
    cycle();
    cycle();
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_error !== 2'b00 || bus.resp_duration !== 8'hFF || m_dur != TMAX) begin
      n_fail++;
      $display("FAIL saturation: rv=%b err=%b dur=%h model=%0d, required rv=1 err=00 dur=ff", bus.resp_valid, bus.resp_error, bus.resp_duration, m_dur);
    end
    cycle();
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.enter_valid = 1; bus.enter_location = 8'h02;
    cycle();
    bus.enter_valid = 0;
    bus.exit_valid = 1; bus.exit_location = 8'h02;
    cycle();
    bus.exit_valid = 0;
    cycle();
    n_checks++;
    if (bus.exit_ready !== 1'b0 || bus.parking_capacity !== 8'h02) begin
      n_fail++; $display("FAIL pre_reset_release: ready=%b cap=%h, required ready=0 cap=02", bus.exit_ready, bus.parking_capacity);
    end
    rst = 1;
    #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.parking_capacity !== 8'h00 || bus.exit_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_immediate: rv=%b cap=%h ready=%b, required rv=0 cap=00 ready=1", bus.resp_valid, bus.parking_capacity, bus.exit_ready);
    end
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    cycle();
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.parking_capacity !== 8'h00 || bus.exit_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_after: rv=%b cap=%h ready=%b, required rv=0 cap=00 ready=1", bus.resp_valid, bus.parking_capacity, bus.exit_ready);
    end
  endtask
  initial begin
    test_reset();
    test_entry();
    test_exit_ok();
    test_exit_errors();
    test_simultaneous();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
